kernel_cc_write_back_start_ctrl: RTL and testbench



---
 rtl/kernel_cc_pkg.sv | 22 ++
 rtl/kernel_cc_sat_counter.sv | 43 ++++
 rtl/kernel_cc_write_back_start_ctrl.sv | 134 +++++++++++++
 tb/tb_kernel_cc_write_back_start_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_cc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kernel_cc_pkg
// Description : Shared types and constants for the kernel_cc write_back
//               start-token controller.
// Revision    : 1.0 - initial release
// ============================================================================
package kernel_cc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        RUN   = 3'd2,
        CONT  = 3'd3,
        FWD   = 3'd4
    } wb_start_state_t;

    localparam int unsigned CNT_WIDTH_DEFAULT = 32;
    localparam logic [CNT_WIDTH_DEFAULT-1:0] CNT_MAX = '1;

endpackage
`default_nettype wire

// File: rtl/kernel_cc_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : kernel_cc_sat_counter
// Description : Saturating up-counter with synchronous clear; increment
//               has priority over clear.
// Revision    : 1.0 - initial release
// ============================================================================
module kernel_cc_sat_counter
    import kernel_cc_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
)(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_inc,
    input  logic                 i_clr,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic [CNT_WIDTH-1:0] o_count_inc
);

    localparam logic [CNT_WIDTH-1:0] c_max = '1;
    localparam logic [CNT_WIDTH-1:0] c_one = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_inc) begin
            if (r_count != c_max) begin
                r_count <= r_count + c_one;
            end
        end else if (i_clr) begin
            r_count <= '0;
        end
    end

    assign o_count     = r_count;
    // Wrapping +1: at saturation this never equals a non-zero target.
    assign o_count_inc = r_count + c_one;

endmodule
`default_nettype wire

// File: rtl/kernel_cc_write_back_start_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : kernel_cc_write_back_start_ctrl
// Description : Pops a start token, runs one ap_ctrl_chain handshake on
//               write_back, forwards the token, and counts completions.
// Revision    : 1.0 - initial release
// ============================================================================
module kernel_cc_write_back_start_ctrl
    import kernel_cc_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEFAULT,
    parameter bit ENABLE_FWD = 1'b1
)(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start_empty_n,
    output logic                  start_read,
    input  logic [DATA_WIDTH-1:0] start_dout,
    output logic                  ap_start,
    input  logic                  ap_ready,
    input  logic                  ap_done,
    input  logic                  ap_idle,
    output logic                  ap_continue,
    input  logic                  next_full_n,
    output logic                  next_write,
    input  logic [CNT_WIDTH-1:0]  num_tasks,
    input  logic                  clear,
    output logic [CNT_WIDTH-1:0]  task_count,
    output logic                  busy,
    output logic                  all_done
);

    wb_start_state_t      r_state;
    wb_start_state_t      w_state_next;
    logic                 w_pop;
    logic                 w_inc;
    logic                 w_hit;
    logic                 r_all_done;
    logic [CNT_WIDTH-1:0] w_count_inc;
    logic                 w_unused;

    assign w_unused = ^{start_dout, ap_idle};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_inc        = 1'b0;
        ap_start     = 1'b0;
        ap_continue  = 1'b0;
        next_write   = 1'b0;
        unique case (r_state)
            IDLE: begin
                // Gated by reset_n so no token is popped while held in reset.
                w_pop = start_empty_n & ~r_all_done & reset_n;
                if (w_pop) begin
                    w_state_next = START;
                end
            end
            START: begin
                ap_start = 1'b1;
                if (ap_ready) begin
                    w_state_next = ap_done ? CONT : RUN;
                end
            end
            RUN: begin
                if (ap_done) begin
                    w_state_next = CONT;
                end
            end
            CONT: begin
                ap_continue  = 1'b1;
                w_inc        = 1'b1;
                w_state_next = ENABLE_FWD ? FWD : IDLE;
            end
            FWD: begin
                next_write = next_full_n;
                if (next_full_n) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign start_read = w_pop;
    assign busy       = (r_state != IDLE);

    kernel_cc_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_task_cnt (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_inc       (w_inc),
        .i_clr       (clear),
        .o_count     (task_count),
        .o_count_inc (w_count_inc)
    );

    // Target is compared only at the increment, never retroactively.
    assign w_hit = w_inc && (num_tasks != '0) && (w_count_inc == num_tasks);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_all_done <= 1'b0;
        end else if (w_inc) begin
            if (w_hit) begin
                r_all_done <= 1'b1;
            end
        end else if (clear) begin
            r_all_done <= 1'b0;
        end
    end

    assign all_done = r_all_done;

    a_cont_single_cycle: assert property (@(posedge clk) disable iff (!reset_n)
        ap_continue |=> !ap_continue);

    a_no_pop_when_done: assert property (@(posedge clk) disable iff (!reset_n)
        start_read |-> !all_done);

endmodule
`default_nettype wire

// File: tb/tb_kernel_cc_write_back_start_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_kernel_cc_write_back_start_ctrl
// Description : Scoreboard bench for the write_back start-token controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kernel_cc_write_back_start_ctrl;

    localparam int CW     = 4;
    localparam int CW_MAX = (1 << CW) - 1;

    logic          clk           = 1'b0;
    logic          reset_n       = 1'b0;
    logic          start_empty_n = 1'b0;
    logic          start_read;
    logic [0:0]    start_dout    = 1'b0;
    logic          ap_start;
    logic          ap_ready      = 1'b0;
    logic          ap_done       = 1'b0;
    logic          ap_idle       = 1'b1;
    logic          ap_continue;
    logic          next_full_n   = 1'b1;
    logic          next_write;
    logic [CW-1:0] num_tasks     = '0;
    logic          clear         = 1'b0;
    logic [CW-1:0] task_count;
    logic          busy;
    logic          all_done;

    kernel_cc_write_back_start_ctrl #(
        .DATA_WIDTH (1),
        .CNT_WIDTH  (CW),
        .ENABLE_FWD (1'b1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start_empty_n (start_empty_n),
        .start_read    (start_read),
        .start_dout    (start_dout),
        .ap_start      (ap_start),
        .ap_ready      (ap_ready),
        .ap_done       (ap_done),
        .ap_idle       (ap_idle),
        .ap_continue   (ap_continue),
        .next_full_n   (next_full_n),
        .next_write    (next_write),
        .num_tasks     (num_tasks),
        .clear         (clear),
        .task_count    (task_count),
        .busy          (busy),
        .all_done      (all_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic          done;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   pushed   = 0;
    int   popped   = 0;
    bit   rand_mode = 1'b0;
    bit   mon_pend  = 1'b0;
    int   n_read, n_start, n_cont, n_write;
    int   last_read_cyc, prev_read_cyc, first_start_cyc, first_cont_cyc;
    // Reference model: completions counted as plain integers.
    int   m_count   = 0;
    bit   m_done    = 1'b0;
    int   m_backlog = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic clr_stats();
        n_read = 0; n_start = 0; n_cont = 0; n_write = 0;
        last_read_cyc = 0; prev_read_cyc = 0; first_start_cyc = 0; first_cont_cyc = 0;
    endtask

    task automatic step();
        bit s_read;
        @(negedge clk);
        s_read = start_read;
        if (start_read) begin n_read++; prev_read_cyc = last_read_cyc; last_read_cyc = cyc; end
        if (ap_start) begin if (n_start == 0) first_start_cyc = cyc; n_start++; end
        if (ap_continue) begin if (n_cont == 0) first_cont_cyc = cyc; n_cont++; end
        if (next_write) n_write++;
        @(posedge clk);
        cyc++;
        #1;
        if (reset_n && s_read) popped++;
        start_empty_n = (pushed != popped);
        if (rand_mode) begin
            ap_ready    = ($urandom_range(0, 2) != 0);
            ap_done     = ($urandom_range(0, 3) == 0);
            next_full_n = ($urandom_range(0, 3) != 0);
        end
        #1;
    endtask

    task automatic model_consume();
        int nxt;
        if (m_done) begin
            m_backlog++;
        end else begin
            nxt = m_count + 1;
            if (nxt <= CW_MAX) m_count = nxt;
            if (num_tasks != 0 && nxt == int'(num_tasks)) m_done = 1'b1;
            sb.push_back(exp_t'{cnt: CW'(m_count), done: m_done});
        end
    endtask

    task automatic model_clear();
        int k;
        m_count = 0; m_done = 1'b0;
        k = m_backlog; m_backlog = 0;
        repeat (k) model_consume();
    endtask

    task automatic push_tokens(input int n);
        repeat (n) begin pushed++; model_consume(); end
        start_empty_n = (pushed != popped);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((sb.size() != 0 || busy || mon_pend) && k < budget) begin
            step();
            k++;
        end
        check("drain_in_budget", 32'(k >= budget), 0);
        if (k >= budget) sb.delete();
    endtask

    task automatic monitor();
        exp_t e;
        bit   pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                check("sb_task_count", 32'(task_count), 32'(e.cnt));
                check("sb_all_done", 32'(all_done), 32'(e.done));
                pend = 1'b0;
            end
            if (reset_n && all_done) check("no_pop_when_done", 32'(start_read), 0);
            if (reset_n && ap_continue) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL sb_unexpected_continue: got ap_continue, expected none (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    pend = 1'b1;
                end
            end
            mon_pend = pend;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        fork monitor(); join_none
        clr_stats();

        // Reset state
        repeat (2) step();
        check("rst_busy", 32'(busy), 0);
        check("rst_start_read", 32'(start_read), 0);
        check("rst_ap_start", 32'(ap_start), 0);
        check("rst_ap_continue", 32'(ap_continue), 0);
        check("rst_next_write", 32'(next_write), 0);
        check("rst_task_count", 32'(task_count), 0);
        check("rst_all_done", 32'(all_done), 0);
        reset_n = 1'b1;
        step();

        // Single token: ready on first START cycle, done 3 cycles later
        ap_ready = 1'b1; ap_done = 1'b0; next_full_n = 1'b1;
        clr_stats();
        push_tokens(1);
        check("t1_pop", 32'(start_read), 1);
        step();
        check("t1_ap_start", 32'(ap_start), 1);
        step();
        check("t1_run_ap_start", 32'(ap_start), 0);
        check("t1_run_busy", 32'(busy), 1);
        step();
        step();
        ap_done = 1'b1; #1;
        check("t1_no_cont_in_run", 32'(ap_continue), 0);
        step();
        ap_done = 1'b0; #1;
        check("t1_ap_continue", 32'(ap_continue), 1);
        step();
        check("t1_next_write", 32'(next_write), 1);
        step();
        check("t1_idle_busy", 32'(busy), 0);
        check("t1_n_start", 32'(n_start), 1);
        check("t1_n_cont", 32'(n_cont), 1);
        check("t1_n_write", 32'(n_write), 1);
        check("t1_n_read", 32'(n_read), 1);

        // Back-to-back tokens with immediate ready+done
        ap_ready = 1'b1; ap_done = 1'b1;
        clr_stats();
        push_tokens(3);
        wait_drain(60);
        check("t2_n_read", 32'(n_read), 3);
        check("t2_period", 32'(last_read_cyc - prev_read_cyc), 4);
        check("t2_start_to_cont", 32'(first_cont_cyc - first_start_cyc), 1);
        check("t2_n_start", 32'(n_start), 3);
        check("t2_task_count", 32'(task_count), 4);

        // Programmed task count reached, then clear
        num_tasks = CW'(6); #1;
        push_tokens(4);
        wait_drain(80);
        check("t3_all_done", 32'(all_done), 1);
        check("t3_task_count", 32'(task_count), 6);
        check("t3_left", 32'(pushed - popped), 32'(m_backlog));
        repeat (5) step();
        check("t3_still_blocked", 32'(start_read), 0);
        check("t3_left_after_wait", 32'(pushed - popped), 2);
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_clear();
        check("t3_clr_count", 32'(task_count), 0);
        check("t3_clr_all_done", 32'(all_done), 0);
        check("t3_resume_pop", 32'(start_read), 1);
        wait_drain(80);
        check("t3_left_final", 32'(pushed - popped), 0);

        // Downstream back-pressure in FWD
        num_tasks = '0; next_full_n = 1'b0; #1;
        push_tokens(2);
        check("t4_pop", 32'(start_read), 1);
        step();
        check("t4_ap_start", 32'(ap_start), 1);
        step();
        check("t4_ap_continue", 32'(ap_continue), 1);
        step();
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_write", 32'(next_write), 0);
            check("t4_hold_pop", 32'(start_read), 0);
            step();
        end
        next_full_n = 1'b1; #1;
        check("t4_release_write", 32'(next_write), 1);
        step();
        check("t4_idle", 32'(busy), 0);
        check("t4_next_pop", 32'(start_read), 1);
        wait_drain(40);

        // Asynchronous reset while in RUN
        ap_ready = 1'b1; ap_done = 1'b0; next_full_n = 1'b1;
        pushed++;
        start_empty_n = (pushed != popped); #1;
        step();
        step();
        check("t5_in_run", 32'(busy), 1);
        #1 reset_n = 1'b0;
        #1;
        check("t5_rst_ap_start", 32'(ap_start), 0);
        check("t5_rst_ap_continue", 32'(ap_continue), 0);
        check("t5_rst_next_write", 32'(next_write), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_count", 32'(task_count), 0);
        m_count = 0; m_done = 1'b0; m_backlog = 0;
        step();
        step();
        reset_n = 1'b1;
        step();
        check("t5_after_busy", 32'(busy), 0);

        // Clear held across a transaction: increment wins in CONT
        num_tasks = CW'(1); clear = 1'b1; ap_done = 1'b1; #1;
        push_tokens(1);
        wait_drain(30);
        check("t6_cleared_count", 32'(task_count), 0);
        check("t6_cleared_done", 32'(all_done), 0);
        clear = 1'b0;
        model_clear();

        // Saturation at all-ones, then a target below the count
        num_tasks = '0; rand_mode = 1'b1;
        step();
        push_tokens(CW_MAX + 2);
        wait_drain(800);
        check("t7_sat_count", 32'(task_count), 32'(CW_MAX));
        check("t7_sat_all_done", 32'(all_done), 0);
        num_tasks = CW'(3); #1;
        push_tokens(1);
        wait_drain(60);
        check("t7_no_retro_done", 32'(all_done), 0);

        // Randomized rounds
        for (int r = 0; r < 12; r++) begin
            num_tasks = CW'($urandom_range(0, 6)); #1;
            if (r % 3 == 0 || m_done) begin
                clear = 1'b1;
                step();
                clear = 1'b0;
                model_clear();
            end
            push_tokens($urandom_range(1, 5));
            wait_drain(400);
            check("rnd_backlog", 32'(pushed - popped), 32'(m_backlog));
            check("rnd_count", 32'(task_count), 32'(m_count));
        end

        rand_mode = 1'b0;
        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
